// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_W         = 5;
    localparam int FLUSH_LEN_MAX = 7;
    localparam int FLUSH_CNT_W   = $clog2(FLUSH_LEN_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detection inputs from the pipeline and control outputs back to it.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic [REG_W-1:0] idex_rd;
    logic             idex_memread;
    logic             exmem_branch;
    logic             exmem_zero;
    logic             ext_stall;

    logic             pc_write;
    logic             ifid_write;
    logic             pc_src;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             hold_all;

    // master: the pipeline datapath; slave: the hazard controller
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, idex_rd, idex_memread,
               exmem_branch, exmem_zero, ext_stall,
        input  pc_write, ifid_write, pc_src, ifid_flush, idex_flush,
               exmem_flush, hold_all
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, idex_rd, idex_memread,
               exmem_branch, exmem_zero, ext_stall,
        output pc_write, ifid_write, pc_src, ifid_flush, idex_flush,
               exmem_flush, hold_all
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / taken-branch flush controller with freeze and event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FLUSH_LEN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_cnt,
    pipe_hazard_ctrl_if.slave   hz,
    output logic [1:0]          state_o,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    state_t                 state_reg, state_next;
    logic [FLUSH_CNT_W-1:0] fcnt_reg, fcnt_next;

    logic branch_taken, load_use;
    logic stall_inc, flush_inc;
    logic pc_write, ifid_write, pc_src;
    logic ifid_flush, idex_flush, exmem_flush, hold_all;

    assign branch_taken = hz.exmem_branch & hz.exmem_zero;
    assign load_use     = hz.idex_memread && (hz.idex_rd != '0) &&
                          ((hz.idex_rd == hz.id_rs1) ||
                           (hz.id_uses_rs2 && (hz.idex_rd == hz.id_rs2)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pc_src      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        hold_all    = 1'b0;
        state_next  = state_reg;
        fcnt_next   = fcnt_reg;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (!reset) begin
            // defaults only; state is cleared by the register
        end else if (hz.ext_stall) begin
            hold_all   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN, ST_STALL: begin
                    if (branch_taken) begin
                        pc_src      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        fcnt_next   = FLUSH_CNT_W'(FLUSH_LEN);
                        state_next  = ST_FLUSH;
                        flush_inc   = 1'b1;
                    end else if (state_reg == ST_RUN && load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        state_next = ST_STALL;
                        stall_inc  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    fcnt_next = fcnt_reg - FLUSH_CNT_W'(1);
                    // <= 1 also recovers from a corrupt zero count
                    if (fcnt_reg <= FLUSH_CNT_W'(1)) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            fcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (clr_cnt),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (clr_cnt),
        .count (flush_cnt)
    );

    assign state_o        = state_reg;
    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.pc_src      = pc_src;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_flush = exmem_flush;
    assign hz.hold_all    = hold_all;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with CNT_W=4 and FLUSH_LEN=3.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [6:0] CTL_DEF   = 7'b1100000;
    localparam logic [6:0] CTL_STALL = 7'b0000100;
    localparam logic [6:0] CTL_BR    = 7'b1111110;
    localparam logic [6:0] CTL_HOLD  = 7'b0000001;

    logic             clk = 1'b0;
    logic             reset;
    logic             clr_cnt;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctl;
    int               total = 0;
    int               passed = 0;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_LEN(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr_cnt   (clr_cnt),
        .hz        (hz),
        .state_o   (state_o),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush, hold_all}
    assign ctl = {hz.pc_write, hz.ifid_write, hz.pc_src, hz.ifid_flush,
                  hz.idex_flush, hz.exmem_flush, hz.hold_all};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs2 = 1'b0;
        hz.idex_rd = 5'd0; hz.idex_memread = 1'b0;
        hz.exmem_branch = 1'b0; hz.exmem_zero = 1'b0; hz.ext_stall = 1'b0;
    endtask

    task automatic set_load_use();
        hz.idex_memread = 1'b1; hz.idex_rd = 5'd5; hz.id_rs1 = 5'd5;
    endtask

    task automatic set_branch();
        hz.exmem_branch = 1'b1; hz.exmem_zero = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        clr_cnt = 1'b0;
        set_load_use();
        set_branch();
        tick(); tick();
        chk("rst_ctl", ctl, CTL_DEF);
        chk("rst_state", state_o, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);

        reset = 1'b1; idle();
        tick();
        chk("idle_ctl", ctl, CTL_DEF);

        // basic load-use stall
        set_load_use(); settle();
        chk("lu_ctl", ctl, CTL_STALL);
        tick(); idle(); settle();
        chk("lu_state", state_o, 1);
        chk("lu_next_ctl", ctl, CTL_DEF);
        chk("lu_stall_cnt", stall_cnt, 1);
        tick();
        chk("lu_back_run", state_o, 0);

        // x0 destination never stalls
        hz.idex_memread = 1'b1; hz.idex_rd = 5'd0; hz.id_rs1 = 5'd0; settle();
        chk("x0_ctl", ctl, CTL_DEF);
        // rs2 match ignored unless rs2 is read
        hz.idex_rd = 5'd7; hz.id_rs1 = 5'd3; hz.id_rs2 = 5'd7; hz.id_uses_rs2 = 1'b0; settle();
        chk("rs2_unused_ctl", ctl, CTL_DEF);
        tick();
        chk("rs2_unused_state", state_o, 0);
        hz.id_uses_rs2 = 1'b1; settle();
        chk("rs2_used_ctl", ctl, CTL_STALL);
        tick(); idle();
        chk("rs2_state", state_o, 1);
        chk("rs2_stall_cnt", stall_cnt, 2);
        tick();

        // branch not taken when zero=0
        hz.exmem_branch = 1'b1; settle();
        chk("br_nz_ctl", ctl, CTL_DEF);

        // taken branch beats load-use; FLUSH lasts 3 cycles
        set_branch(); set_load_use(); settle();
        chk("br_ctl", ctl, CTL_BR);
        tick(); idle();
        chk("fl1_state", state_o, 2);
        chk("fl_flush_cnt", flush_cnt, 1);
        chk("fl_stall_cnt", stall_cnt, 2);
        set_branch(); set_load_use(); settle();
        chk("fl_ignore_ctl", ctl, CTL_DEF);
        tick(); idle();
        chk("fl2_state", state_o, 2);
        tick();
        chk("fl3_state", state_o, 2);
        tick();
        chk("fl_done_state", state_o, 0);
        chk("fl_done_fcnt", flush_cnt, 1);

        // freeze during FLUSH
        set_branch(); tick(); idle();
        chk("fz_enter", state_o, 2);
        tick();
        for (int i = 0; i < 4; i++) begin
            hz.ext_stall = 1'b1; set_branch(); set_load_use(); settle();
            chk("fz_ctl", ctl, CTL_HOLD);
            tick();
            chk("fz_state", state_o, 2);
        end
        idle(); settle();
        chk("fz_rel_ctl", ctl, CTL_DEF);
        tick();
        chk("fz_rel1_state", state_o, 2);
        tick();
        chk("fz_rel2_state", state_o, 0);
        chk("fz_flush_cnt", flush_cnt, 2);

        // freeze in RUN overrides load-use and does not count
        hz.ext_stall = 1'b1; set_load_use(); settle();
        chk("fz_run_ctl", ctl, CTL_HOLD);
        tick();
        chk("fz_run_state", state_o, 0);
        chk("fz_run_scnt", stall_cnt, 2);
        idle();

        // STALL with taken branch goes to FLUSH
        set_load_use(); tick();
        chk("st_br_state0", state_o, 1);
        set_branch(); settle();
        chk("st_br_ctl", ctl, CTL_BR);
        tick(); idle();
        chk("st_br_state", state_o, 2);
        chk("st_br_fcnt", flush_cnt, 3);
        tick(); tick(); tick();
        chk("st_br_done", state_o, 0);

        // saturation: 20 more load-use events
        set_load_use();
        for (int i = 0; i < 40; i++) tick();
        chk("sat_state", state_o, 0);
        chk("sat_stall_cnt", stall_cnt, 15);

        // clear overrides a same-cycle stall event, FSM still moves
        clr_cnt = 1'b1; settle();
        chk("clr_ctl", ctl, CTL_STALL);
        tick(); clr_cnt = 1'b0;
        chk("clr_stall_cnt", stall_cnt, 0);
        chk("clr_flush_cnt", flush_cnt, 0);
        chk("clr_state", state_o, 1);
        tick();
        chk("clr_back_run", state_o, 0);

        // reset mid-STALL
        tick();
        chk("rs_state_stall", state_o, 1);
        chk("rs_scnt_pre", stall_cnt, 1);
        reset = 1'b0; set_branch(); settle();
        chk("rs_low_ctl", ctl, CTL_DEF);
        tick();
        chk("rs_state", state_o, 0);
        chk("rs_stall_cnt", stall_cnt, 0);
        chk("rs_flush_cnt", flush_cnt, 0);
        chk("rs_low_ctl2", ctl, CTL_DEF);
        reset = 1'b1; idle(); settle();
        chk("rs_rel_ctl", ctl, CTL_DEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
